pattern_dump: RTL and testbench

- Reader counterpart to the pattern-RAM write path (`p`/`w` commands).
- On request, reads a run of 72-bit words from the pattern RAM and streams them back to the host through the UART transmitter, one byte at a time.
- Byte order matches the `p` shift order, MSB byte first, so the host can replay a dump verbatim.
- Sits between the command decoder, the pattern RAM read port and uart_tx.

---
 rtl/pattern_dump.sv | 165 ++++++++++++++++
 tb/tb_pattern_dump.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_dump.sv
// Streams a run of pattern-RAM words to uart_tx as an address byte followed by data bytes, MSB first.
// Define PATTERN_DUMP_CSUM_EN to append an XOR checksum byte to every word frame.
module pattern_dump #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_BYTES = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic [ADDR_WIDTH-1:0]   length,
    output logic                    ram_req,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_BYTES*8-1:0] rd_data,
    output logic [7:0]              tx_byte,
    output logic                    tx_go,
    input  logic                    tx_busy,
    output logic                    busy,
    output logic                    done
);

    localparam int DATA_W = DATA_BYTES * 8;
    localparam int REM_W  = ADDR_WIDTH + 1;
`ifdef PATTERN_DUMP_CSUM_EN
    localparam int FRAME_BYTES = DATA_BYTES + 2;
`else
    localparam int FRAME_BYTES = DATA_BYTES + 1;
`endif
    localparam int IDX_W = $clog2(FRAME_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        GUARD,
        WAIT,
        FIN
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [REM_W-1:0]        remaining;
    logic [DATA_W-1:0]       shreg;
    logic [IDX_W-1:0]        byte_idx;
    logic [7:0]              addr_byte;
    logic                    word_last;
    logic                    last_word;
`ifdef PATTERN_DUMP_CSUM_EN
    logic [7:0]              csum;
`endif

    // Address byte on the wire is the low 8 bits of the address, zero-extended when narrower.
    generate
        if (ADDR_WIDTH >= 8) begin : g_addr_trunc
            assign addr_byte = cur_addr[7:0];
        end else begin : g_addr_ext
            assign addr_byte = {{(8 - ADDR_WIDTH){1'b0}}, cur_addr};
        end
    endgenerate

    assign rd_addr   = cur_addr;
    assign word_last = (byte_idx == IDX_W'(FRAME_BYTES - 1));
    assign last_word = (remaining == REM_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    state_d = LATCH;
            LATCH:   state_d = SEND;
            SEND:    state_d = GUARD;
            GUARD:   state_d = WAIT;
            WAIT: begin
                if (!tx_busy) begin
                    if (!word_last) begin
                        state_d = SEND;
                    end else if (last_word) begin
                        state_d = FIN;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        ram_req = (state_q != IDLE);
        tx_go   = (state_q == SEND);
        done    = (state_q == FIN);
    end

    // tx_byte only moves in LATCH or an idle WAIT, so it stays put for the whole uart_tx transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            shreg     <= '0;
            byte_idx  <= '0;
            tx_byte   <= '0;
`ifdef PATTERN_DUMP_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_addr <= start_addr;
                        if (length == '0) begin
                            remaining <= {1'b1, {ADDR_WIDTH{1'b0}}};
                        end else begin
                            remaining <= {1'b0, length};
                        end
                    end
                end
                LATCH: begin
                    shreg    <= rd_data;
                    tx_byte  <= addr_byte;
                    byte_idx <= '0;
`ifdef PATTERN_DUMP_CSUM_EN
                    csum     <= addr_byte;
`endif
                end
                WAIT: begin
                    if (!tx_busy) begin
                        if (!word_last) begin
                            byte_idx <= byte_idx + 1'b1;
`ifdef PATTERN_DUMP_CSUM_EN
                            if (byte_idx == IDX_W'(DATA_BYTES)) begin
                                tx_byte <= csum;
                            end else begin
                                tx_byte <= shreg[DATA_W-1 -: 8];
                                shreg   <= {shreg[DATA_W-9:0], 8'h00};
                                csum    <= csum ^ shreg[DATA_W-1 -: 8];
                            end
`else
                            tx_byte <= shreg[DATA_W-1 -: 8];
                            shreg   <= {shreg[DATA_W-9:0], 8'h00};
`endif
                        end else begin
                            remaining <= remaining - 1'b1;
                            cur_addr  <= cur_addr + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_dump.sv
// Directed bench for pattern_dump: RAM and uart_tx models, captured byte stream checked against frames
// rebuilt from the RAM image. Honours PATTERN_DUMP_CSUM_EN for the checksum byte.
module tb_pattern_dump;

`ifdef PATTERN_DUMP_CSUM_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    typedef struct {
        logic [7:0] saddr;
        logic [7:0] len;
        int         busy_len;
        int         words;
        int         gap;
        int         inj_at;
        int         mod_at;
        string      name;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  start_addr;
    logic [7:0]  length;
    logic        ram_req;
    logic [7:0]  rd_addr;
    logic [71:0] rd_data;
    logic [7:0]  tx_byte;
    logic        tx_go;
    logic        tx_busy = 1'b0;
    logic        busy;
    logic        done;

    logic [71:0] mem [256];
    logic [7:0]  cap_q [$];
    int          cap_cyc [$];
    logic [7:0]  exp_q [$];
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          busy_len_g = 0;
    int          busy_cnt = 0;
    int          stable_err = 0;
    logic [7:0]  held = 8'h00;
    int          n_vec = 0;
    int          n_miss = 0;
    vec_t        vecs [6];

    pattern_dump dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .ram_req    (ram_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx_byte    (tx_byte),
        .tx_go      (tx_go),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Synchronous-read pattern RAM
    always @(posedge clk) rd_data <= mem[rd_addr];

    // uart_tx stand-in: busy for busy_len_g cycles starting the cycle after tx_go
    always @(posedge clk) begin
        #1;
        if (busy_cnt > 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
        end else begin
            tx_busy = 1'b0;
        end
        if (tx_go && busy_len_g > 0) busy_cnt = busy_len_g;
    end

    always @(negedge clk) begin
        if (tx_go) begin
            cap_q.push_back(tx_byte);
            cap_cyc.push_back(cyc);
            held = tx_byte;
        end else if (tx_busy && tx_byte !== held) begin
            stable_err++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check_output(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic build_expected(input logic [7:0] sa, input int words);
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  x;
        logic [71:0] w;
        exp_q.delete();
        for (int i = 0; i < words; i++) begin
            a = sa + 8'(i);
            w = mem[a];
            x = a;
            exp_q.push_back(a);
            for (int k = 0; k < 9; k++) begin
                b = w[71 - 8*k -: 8];
                x = x ^ b;
                exp_q.push_back(b);
            end
`ifdef PATTERN_DUMP_CSUM_EN
            exp_q.push_back(x);
`endif
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] sa, input logic [7:0] len);
        @(negedge clk);
        start_addr = sa;
        length     = len;
        start      = 1'b1;
        start_cyc  = cyc;
        @(negedge clk);
        start      = 1'b0;
        start_addr = ~sa;
        length     = ~len;
    endtask

    task automatic run_dump(input vec_t v);
        int          waited;
        int          errs;
        int          min_gap;
        int          n;
        bit          injected;
        bit          modded;
        logic [71:0] saved;
        cap_q.delete();
        cap_cyc.delete();
        done_cnt   = 0;
        stable_err = 0;
        busy_len_g = v.busy_len;
        build_expected(v.saddr, v.words);
        saved = mem[v.saddr];
        apply_stimulus(v.saddr, v.len);
        waited   = 0;
        injected = 1'b0;
        modded   = 1'b0;
        while (done_cnt == 0 && waited < 20000) begin
            @(negedge clk);
            waited++;
            start = 1'b0;
            if (v.inj_at > 0 && !injected && cap_q.size() >= v.inj_at) begin
                start_addr = 8'h40;
                length     = 8'h05;
                start      = 1'b1;
                injected   = 1'b1;
            end
            if (v.mod_at > 0 && !modded && cap_q.size() >= v.mod_at) begin
                mem[v.saddr] = '1;
                modded       = 1'b1;
            end
        end
        start = 1'b0;
        check_output({v.name, ":done_seen"}, longint'(done_cnt > 0), 1);
        repeat (2) @(negedge clk);
        mem[v.saddr] = saved;
        n = cap_q.size();
        check_output({v.name, ":byte_count"}, n, exp_q.size());
        errs = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= n || cap_q[i] !== exp_q[i]) begin
                if (errs == 0 && i < n)
                    $display("[TB] %s first differing byte #%0d: 0x%0h vs 0x%0h", v.name, i, cap_q[i], exp_q[i]);
                errs++;
            end
        end
        check_output({v.name, ":byte_errors"}, errs, 0);
        check_output({v.name, ":latency"}, (n > 0) ? cap_cyc[0] - start_cyc : -1, 3);
        min_gap = 0;
        for (int i = 1; i < n; i++) begin
            if (i == 1 || cap_cyc[i] - cap_cyc[i-1] < min_gap) min_gap = cap_cyc[i] - cap_cyc[i-1];
        end
        check_output({v.name, ":min_gap"}, min_gap, v.gap);
        check_output({v.name, ":done_gap"}, (n > 0) ? done_cyc - cap_cyc[n-1] : -1, v.gap);
        check_output({v.name, ":done_count"}, done_cnt, 1);
        check_output({v.name, ":busy_after"}, busy, 0);
        check_output({v.name, ":ram_req_after"}, ram_req, 0);
        check_output({v.name, ":tx_byte_stable"}, stable_err, 0);
    endtask

    initial begin
        int waited;
        for (int a = 0; a < 256; a++) begin
            for (int k = 0; k < 9; k++) begin
                mem[a][71 - 8*k -: 8] = 8'(a * 7 + k * 29 + 3);
            end
        end
        mem[5] = 72'h010203040506070809;

        vecs[0] = '{8'h05, 8'h01, 0,  1,   3,  0, 0, "single"};
        vecs[1] = '{8'h05, 8'h01, 20, 1,   22, 0, 0, "slow_uart"};
        vecs[2] = '{8'hFE, 8'h03, 0,  3,   3,  0, 0, "wrap"};
        vecs[3] = '{8'h00, 8'h00, 0,  256, 3,  0, 0, "full_256"};
        vecs[4] = '{8'h10, 8'h02, 3,  2,   5,  3, 0, "start_ignored"};
        vecs[5] = '{8'h05, 8'h01, 5,  1,   7,  0, 2, "ram_change"};

        rst        = 1'b1;
        start      = 1'b0;
        start_addr = 8'h00;
        length     = 8'h00;
        repeat (3) @(negedge clk);
        check_output("reset:ram_req", ram_req, 0);
        check_output("reset:rd_addr", rd_addr, 0);
        check_output("reset:tx_byte", tx_byte, 0);
        check_output("reset:tx_go", tx_go, 0);
        check_output("reset:busy", busy, 0);
        check_output("reset:done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check_output("idle:busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            run_dump(vecs[i]);
        end

        // Reset in the middle of the 4th byte: everything drops next cycle, no done
        cap_q.delete();
        cap_cyc.delete();
        done_cnt   = 0;
        busy_len_g = 0;
        apply_stimulus(8'h20, 8'h02);
        waited = 0;
        while (cap_q.size() < 4 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_output("rst_mid:reached_4th", longint'(cap_q.size() >= 4), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rst_mid:tx_go", tx_go, 0);
        check_output("rst_mid:busy", busy, 0);
        check_output("rst_mid:ram_req", ram_req, 0);
        check_output("rst_mid:rd_addr", rd_addr, 0);
        check_output("rst_mid:tx_byte", tx_byte, 0);
        repeat (30) @(negedge clk);
        check_output("rst_mid:no_done", done_cnt, 0);
        check_output("rst_mid:no_more_bytes", cap_q.size(), 4);

        run_dump('{8'h07, 8'h01, 0, 1, 3, 0, 0, "after_rst"});

        // start coinciding with rst must be dropped
        cap_q.delete();
        @(negedge clk);
        rst        = 1'b1;
        start      = 1'b1;
        start_addr = 8'h33;
        length     = 8'h01;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_output("rst_start:busy", busy, 0);
        repeat (5) @(negedge clk);
        check_output("rst_start:busy_later", busy, 0);
        check_output("rst_start:no_bytes", cap_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
